// File: rtl/piso_deb_ctrl.sv
// piso_deb_ctrl: frame sequencer for the debug PISO.
// Drives CLR/EN/SHIFT and flags each byte on D_OUT.
//
// Ports:
//   CLKEXT, RST_GLO (sync, active high)
//   DBG_START, DBG_ABORT, AUTO_EN, AUTO_PERIOD  : triggers
//   DBG_RDY                                    : consumer ready
//   CLR_PISO_DEB, EN_PISO_DEB, SHIFT_DEB       : PISO control
//   BYTE_VLD, BYTE_IDX                         : byte strobe, aligned with D_OUT
//   FRAME_DONE, BUSY, OVERRUN                  : status
module piso_deb_ctrl #(
    parameter int NBYTES   = 12,
    parameter int PERIOD_W = 16
) (
    input  logic                CLKEXT,
    input  logic                RST_GLO,
    input  logic                DBG_START,
    input  logic                DBG_ABORT,
    input  logic                AUTO_EN,
    input  logic [PERIOD_W-1:0] AUTO_PERIOD,
    input  logic                DBG_RDY,
    output logic                CLR_PISO_DEB,
    output logic                EN_PISO_DEB,
    output logic                SHIFT_DEB,
    output logic                BYTE_VLD,
    output logic [3:0]          BYTE_IDX,
    output logic                FRAME_DONE,
    output logic                BUSY,
    output logic                OVERRUN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CAPTURE,
        S_SHIFTING,
        S_DRAIN,
        S_ABORT
    } state_t;

    localparam logic [3:0] NB   = 4'(NBYTES);
    localparam logic [3:0] LAST = 4'(NBYTES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          sent;
    logic [PERIOD_W-1:0] auto_cnt;
    logic                auto_on;
    logic                auto_tick;
    logic                trig;

    // A count at or above a freshly lowered period wraps at once.
    assign auto_on   = AUTO_EN && (AUTO_PERIOD != '0);
    assign auto_tick = auto_on &&
                       (auto_cnt >= (AUTO_PERIOD - PERIOD_W'(1)));
    assign trig      = DBG_START || auto_tick;

    // Shift has no skid: it follows DBG_RDY in the same cycle.
    assign SHIFT_DEB = (state == S_SHIFTING) && DBG_RDY && (sent < NB);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                // Abort wins over a same-cycle trigger.
                if (!DBG_ABORT && trig)
                    state_nxt = S_CLEAR;
            end
            S_CLEAR:    state_nxt = S_CAPTURE;
            S_CAPTURE:  state_nxt = S_SHIFTING;
            S_SHIFTING: begin
                if (SHIFT_DEB && (sent == LAST))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN:    state_nxt = S_IDLE;
            S_ABORT:    state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (DBG_ABORT && (state != S_IDLE) && (state != S_ABORT))
            state_nxt = S_ABORT;
    end

    // Outputs are decoded from the next state and registered,
    // so they are clean Moore decodes of the state register.
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            state        <= S_IDLE;
            sent         <= '0;
            auto_cnt     <= '0;
            CLR_PISO_DEB <= 1'b0;
            EN_PISO_DEB  <= 1'b0;
            BYTE_VLD     <= 1'b0;
            BYTE_IDX     <= '0;
            FRAME_DONE   <= 1'b0;
            BUSY         <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (!auto_on || auto_tick)
                auto_cnt <= '0;
            else
                auto_cnt <= auto_cnt + PERIOD_W'(1);

            if (state_nxt == S_CLEAR)
                sent <= '0;
            else if (SHIFT_DEB)
                sent <= sent + 4'd1;

            // A shift on the abort edge is never flagged as a byte.
            BYTE_VLD <= SHIFT_DEB && !DBG_ABORT;
            BYTE_IDX <= sent;

            CLR_PISO_DEB <= (state_nxt == S_CLEAR) ||
                            (state_nxt == S_ABORT);
            EN_PISO_DEB  <= (state_nxt == S_CAPTURE) ||
                            (state_nxt == S_SHIFTING) ||
                            (state_nxt == S_DRAIN);
            BUSY         <= (state_nxt != S_IDLE);
            FRAME_DONE   <= (state == S_DRAIN) && (state_nxt == S_IDLE);
            OVERRUN      <= trig && (state != S_IDLE);
        end
    end

endmodule
